alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 52 +++++
 rtl/alu_arbiter.sv | 97 +++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals between two requesters,
// one external combinational ALU and the response consumer.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_in1;
    logic [WIDTH-1:0] req0_in2;
    logic [OPW-1:0]   req0_op;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_in1;
    logic [WIDTH-1:0] req1_in2;
    logic [OPW-1:0]   req1_op;
    logic             req1_ready;

    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_res;
    logic             rsp_zero;
    logic             rsp_ready;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_op,
        input  req1_valid, req1_in1, req1_in2, req1_op,
        output req0_ready, req1_ready,
        output alu_in1, alu_in2, alu_op,
        input  alu_res, alu_zero,
        output rsp_valid, rsp_id, rsp_res, rsp_zero,
        input  rsp_ready
    );

    // Requesters, ALU and response consumer side.
    modport master (
        output req0_valid, req0_in1, req0_in2, req0_op,
        output req1_valid, req1_in1, req1_in2, req1_op,
        input  req0_ready, req1_ready,
        input  alu_in1, alu_in2, alu_op,
        output alu_res, alu_zero,
        input  rsp_valid, rsp_id, rsp_res, rsp_zero,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a single registered response slot that sustains one operation per cycle.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input logic         clk,
    input logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic             r_rsp_id;
    logic             r_rsp_zero;
    logic [WIDTH-1:0] r_rsp_res;

    logic             w_can_accept;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_accept0;
    logic             w_accept1;
    logic             w_accept;
    logic [WIDTH-1:0] w_alu_in1;
    logic [WIDTH-1:0] w_alu_in2;
    logic [OPW-1:0]   w_alu_op;

    // The slot can take a new result when empty or when it is being drained now.
    assign w_can_accept = (r_state == ST_EMPTY) | bus.rsp_ready;

    // On a tie the requester that did not win the last accept goes next.
    assign w_grant0 = bus.req0_valid & (~bus.req1_valid | r_last_grant);
    assign w_grant1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);

    // Ready is held low while reset is asserted so nothing is taken during reset.
    assign w_ready0 = w_grant0 & w_can_accept & ~reset;
    assign w_ready1 = w_grant1 & w_can_accept & ~reset;

    assign w_accept0 = bus.req0_valid & w_ready0;
    assign w_accept1 = bus.req1_valid & w_ready1;
    assign w_accept  = w_accept0 | w_accept1;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_alu_in1 = '0;
        w_alu_in2 = '0;
        w_alu_op  = '0;
        if (w_grant0) begin
            w_alu_in1 = bus.req0_in1;
            w_alu_in2 = bus.req0_in2;
            w_alu_op  = bus.req0_op;
        end else if (w_grant1) begin
            w_alu_in1 = bus.req1_in1;
            w_alu_in2 = bus.req1_in2;
            w_alu_op  = bus.req1_op;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_EMPTY;
            r_last_grant <= 1'b1;
            r_rsp_id     <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_res    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (w_accept) begin
                r_rsp_res    <= bus.alu_res;
                r_rsp_zero   <= bus.alu_zero;
                r_rsp_id     <= w_accept1;
                r_last_grant <= w_accept1;
            end
            case (r_state)
                ST_EMPTY: if (w_accept) r_state <= ST_FULL;
                ST_FULL:  if (!w_accept && bus.rsp_ready) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.alu_in1    = w_alu_in1;
    assign bus.alu_in2    = w_alu_in2;
    assign bus.alu_op     = w_alu_op;
    assign bus.rsp_valid  = (r_state == ST_FULL);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_res    = r_rsp_res;
    assign bus.rsp_zero   = r_rsp_zero;
endmodule
